// File: rtl/hack_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_mem_pkg
// Description : Shared widths and enumerations for the Hack data-memory
//               arbiter (CPU data port vs. screen-refresh reader).
// Revision    : 1.0 - initial release
// ============================================================================
package hack_mem_pkg;

    // Default memory geometry: 16-bit words, 15-bit word address
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    // Identity of the requester that owns an access
    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_SCR = 1'b1
    } owner_t;

    // Arbiter history: nobody recent, CPU last, or screen holding a locked burst
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU       = 2'd1,
        SCR_BURST = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hack_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Bit 0 is the CPU, bit 1 the
//               screen. On a tie the requester that did not win last time
//               is granted; a lone request is always granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0]           req,
    input  hack_mem_pkg::owner_t last_winner,
    output logic [1:0]           gnt
);
    import hack_mem_pkg::*;

    // One-hot grant: tie broken against the previous winner
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last_winner == OWN_SCR) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hack_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hack_mem_arbiter
// Description : Shares one Hack data memory between the CPU data port and
//               the screen-refresh reader. One access per clock, round-robin,
//               with an optional bounded screen burst lock. Read data from
//               the one-cycle-latency memory is steered back to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_mem_arbiter #(
    parameter int ADDR_W    = hack_mem_pkg::ADDR_W,
    parameter int DATA_W    = hack_mem_pkg::DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    // CPU data port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // Screen refresh reader (read-only)
    input  logic              scr_req,
    input  logic              scr_lock,
    input  logic [ADDR_W-1:0] scr_addr,
    output logic              scr_gnt,
    output logic              scr_rvalid,
    output logic [DATA_W-1:0] scr_rdata,
    // Memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);
    import hack_mem_pkg::*;

    // Counter wide enough to hold MAX_BURST itself; it saturates there
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t            r_state;
    owner_t            r_last_winner;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_rd_pending;
    owner_t            r_rd_owner;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_scr_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_in;

    state_t            w_state_nxt;
    owner_t            w_last_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_req;
    logic [1:0]        w_rr_gnt;
    logic [1:0]        w_gnt;
    logic              w_burst_hold;
    logic              w_rd_issue;

    // Requests are ignored entirely while reset is asserted
    assign w_req = {scr_req, cpu_req} & {2{reset_n}};

    rr_arb2 u_rr_arb2 (
        .req         (w_req),
        .last_winner (r_last_winner),
        .gnt         (w_rr_gnt)
    );

    // A locked screen burst below its bound overrides round-robin; once the
    // bound is reached (or the lock drops) round-robin with last_winner=SCR
    // hands a tie to the CPU, while a lone screen request keeps going.
    assign w_burst_hold = (r_state == SCR_BURST) && scr_req && scr_lock &&
                          (r_burst_cnt < C_MAX_CNT) && reset_n;
    assign w_gnt        = w_burst_hold ? 2'b10 : w_rr_gnt;
    assign cpu_gnt      = w_gnt[0];
    assign scr_gnt      = w_gnt[1];

    // Memory port follows the winner; holds its last address/data when idle
    always_comb begin
        mem_load = cpu_gnt & cpu_we;
        mem_addr = reset_n ? r_mem_addr : '0;
        mem_in   = reset_n ? r_mem_in   : '0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_in   = cpu_wdata;
        end else if (scr_gnt) begin
            mem_addr = scr_addr;
        end
    end

    // Any granted read (screen always reads) expects data next cycle
    assign w_rd_issue = (cpu_gnt & ~cpu_we) | scr_gnt;

    // Read return: memory data passes straight through on the rvalid cycle,
    // otherwise the last returned word is presented
    always_comb begin
        cpu_rvalid = reset_n & r_rd_pending & (r_rd_owner == OWN_CPU);
        scr_rvalid = reset_n & r_rd_pending & (r_rd_owner == OWN_SCR);
        cpu_rdata  = cpu_rvalid ? mem_out : (reset_n ? r_cpu_rdata : '0);
        scr_rdata  = scr_rvalid ? mem_out : (reset_n ? r_scr_rdata : '0);
    end

    // Next-state, round-robin history and burst-count update
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_winner;
        w_cnt_nxt   = r_burst_cnt;
        if (w_req == 2'b00) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (cpu_gnt) begin
            w_state_nxt = CPU;
            w_last_nxt  = OWN_CPU;
            w_cnt_nxt   = '0;
        end else if (scr_gnt) begin
            w_last_nxt = OWN_SCR;
            if (scr_lock) begin
                w_state_nxt = SCR_BURST;
                if (r_state != SCR_BURST) begin
                    w_cnt_nxt = C_ONE;
                end else if (r_burst_cnt != C_MAX_CNT) begin
                    w_cnt_nxt = r_burst_cnt + C_ONE;
                end
            end else begin
                // Unlocked screen grant: plain round-robin, CPU wins next tie
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        end
    end

    // State, read-return pipeline and held memory/rdata registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_last_winner <= OWN_SCR;
            r_burst_cnt   <= '0;
            r_rd_pending  <= 1'b0;
            r_rd_owner    <= OWN_CPU;
            r_cpu_rdata   <= '0;
            r_scr_rdata   <= '0;
            r_mem_addr    <= '0;
            r_mem_in      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_winner <= w_last_nxt;
            r_burst_cnt   <= w_cnt_nxt;
            r_rd_pending  <= w_rd_issue;
            r_rd_owner    <= scr_gnt ? OWN_SCR : OWN_CPU;
            if (cpu_rvalid) begin
                r_cpu_rdata <= mem_out;
            end
            if (scr_rvalid) begin
                r_scr_rdata <= mem_out;
            end
            if (cpu_gnt | scr_gnt) begin
                r_mem_addr <= mem_addr;
            end
            if (cpu_gnt) begin
                r_mem_in <= cpu_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_mem_arbiter
// Description : Directed self-checking bench for hack_mem_arbiter with a
//               behavioural one-cycle-latency memory and a read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, scr_req, scr_lock;
    logic [14:0] cpu_addr, scr_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, scr_gnt, scr_rvalid;
    logic [15:0] cpu_rdata, scr_rdata;
    logic [14:0] mem_addr;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out = 16'h0000;

    int tests  = 0;
    int errors = 0;

    logic [15:0] tbmem [0:32767];
    logic [15:0] q_cpu [$];
    logic [15:0] q_scr [$];
    logic        exp_cpu_rv = 1'b0;
    logic        exp_scr_rv = 1'b0;

    hack_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_BURST(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .scr_req    (scr_req),
        .scr_lock   (scr_lock),
        .scr_addr   (scr_addr),
        .scr_gnt    (scr_gnt),
        .scr_rvalid (scr_rvalid),
        .scr_rdata  (scr_rdata),
        .mem_addr   (mem_addr),
        .mem_load   (mem_load),
        .mem_in     (mem_in),
        .mem_out    (mem_out)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read-first, data available one cycle after address
    always @(posedge clk) begin
        mem_out <= tbmem[mem_addr];
        if (mem_load) tbmem[mem_addr] <= mem_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: reads granted this cycle are expected back next cycle
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
            check("rst_scr_rvalid", {31'd0, scr_rvalid}, 32'd0);
            q_cpu.delete();
            q_scr.delete();
            exp_cpu_rv = 1'b0;
            exp_scr_rv = 1'b0;
        end else begin
            check("cpu_rvalid_timing", {31'd0, cpu_rvalid}, {31'd0, exp_cpu_rv});
            check("scr_rvalid_timing", {31'd0, scr_rvalid}, {31'd0, exp_scr_rv});
            if (exp_cpu_rv && q_cpu.size() > 0) check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, q_cpu.pop_front()});
            if (exp_scr_rv && q_scr.size() > 0) check("scr_rdata", {16'd0, scr_rdata}, {16'd0, q_scr.pop_front()});
            check("gnt_onehot", {31'd0, cpu_gnt & scr_gnt}, 32'd0);
            check("gnt_without_req", {31'd0, (cpu_gnt & ~cpu_req) | (scr_gnt & ~scr_req)}, 32'd0);
            exp_cpu_rv = cpu_gnt && !cpu_we;
            exp_scr_rv = scr_gnt;
            if (exp_cpu_rv) q_cpu.push_back(tbmem[cpu_addr]);
            if (exp_scr_rv) q_scr.push_back(tbmem[scr_addr]);
        end
    end

    // Drive one cycle of inputs just after the edge, then sample mid-cycle
    task automatic step(input logic rn, input logic creq, input logic sreq,
                        input logic we, input logic lock);
        @(posedge clk);
        #1;
        reset_n  = rn;
        cpu_req  = creq;
        scr_req  = sreq;
        cpu_we   = we;
        scr_lock = lock;
        @(negedge clk);
    endtask

    task automatic expect_gnt(input string tag, input logic c, input logic s);
        check({tag, "_cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, c});
        check({tag, "_scr_gnt"}, {31'd0, scr_gnt}, {31'd0, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32768; i++) tbmem[i] = 16'(i * 7) ^ 16'hA5C3;
        reset_n = 1'b0; cpu_req = 1'b1; scr_req = 1'b1; cpu_we = 1'b0; scr_lock = 1'b0;
        cpu_addr = 15'h0100; scr_addr = 15'h4000; cpu_wdata = 16'h0000;

        // Reset held two cycles with both requesting
        @(negedge clk);
        expect_gnt("reset0", 1'b0, 1'b0);
        check("reset0_mem_load", {31'd0, mem_load}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_gnt("reset1", 1'b0, 1'b0);
        check("reset1_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("reset1_mem_in", {16'd0, mem_in}, 32'd0);
        check("reset1_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("reset1_scr_rdata", {16'd0, scr_rdata}, 32'd0);

        // First tie after reset goes to the CPU
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_gnt("first_tie", 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_gnt("idle", 1'b0, 1'b0);

        // CPU write then read back
        cpu_addr = 15'h0010; cpu_wdata = 16'hBEEF;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_gnt("wr", 1'b1, 1'b0);
        check("wr_mem_load", {31'd0, mem_load}, 32'd1);
        check("wr_mem_addr", {17'd0, mem_addr}, 32'h10);
        check("wr_mem_in", {16'd0, mem_in}, 32'hBEEF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_gnt("rd", 1'b1, 1'b0);
        check("rd_mem_load", {31'd0, mem_load}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("rd_cpu_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
        check("rd_scr_rvalid", {31'd0, scr_rvalid}, 32'd0);
        check("idle_mem_addr_hold", {17'd0, mem_addr}, 32'h10);
        check("idle_mem_in_hold", {16'd0, mem_in}, 32'hBEEF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rdata_hold", {16'd0, cpu_rdata}, 32'hBEEF);
        check("rvalid_single_pulse", {31'd0, cpu_rvalid}, 32'd0);

        // Unlocked contention: last winner was CPU, so screen goes first
        cpu_addr = 15'h0123; scr_addr = 15'h4321;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            expect_gnt("contend", i[0], ~i[0]);
        end

        // CPU-only back-to-back reads: one grant per cycle
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 15'(15'h0200 + i);
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            expect_gnt("cpu_b2b", 1'b1, 1'b0);
        end

        // Locked burst: 8 screen grants, one CPU, then screen resumes
        cpu_addr = 15'h0300;
        for (int i = 0; i < 10; i++) begin
            scr_addr = 15'(15'h4400 + i);
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            expect_gnt("burst", (i == 8), (i != 8));
        end
        // Two more screen grants (three in this burst), then lock drops
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            expect_gnt("burst2", 1'b0, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_gnt("lock_drop", 1'b1, 1'b0);

        // Screen alone runs past the bound; counter must not wrap
        for (int i = 0; i < 11; i++) begin
            scr_addr = 15'(15'h5000 + i);
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            expect_gnt("scr_alone", 1'b0, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_gnt("sat_cpu", 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_gnt("sat_resume", 1'b0, 1'b1);

        // Reset during a read return: no rvalid, outputs cleared
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_gnt("pre_rst_rd", 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_gnt("mid_rst", 1'b0, 1'b0);
        check("mid_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("mid_rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        check("mid_rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_gnt("post_rst_tie", 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hack_mem_arbiter.md
Name: hack_mem_arbiter

Overview:
Shares a single Hack data memory (16-bit words, 15-bit address) between two requesters: the CPU data port and the screen-refresh reader.
- Arbitrates one access per clock, round-robin.
- The screen requester can lock a bounded burst of consecutive grants.
- Routes the memory's one-cycle-latency read data back to the requester that issued the read.
- Sits between the CPU/screen logic and the RAM16K+screen memory block.

Parameters:
ADDR_W, 15, address width in words
DATA_W, 16, word width
MAX_BURST, 8, max consecutive screen grants while lock held and CPU waiting (range 1..255)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
scr_req  in  1  screen access request, held until scr_gnt
scr_lock  in  1  screen requests burst ownership
scr_addr  in  ADDR_W  screen address; screen is read-only
scr_gnt  out  1  screen access accepted this cycle
scr_rvalid  out  1  screen read data valid
scr_rdata  out  DATA_W  screen read data
mem_addr  out  ADDR_W  memory address
mem_load  out  1  memory write enable
mem_in  out  DATA_W  memory write data
mem_out  in  DATA_W  memory read data, valid one cycle after address presented

Behaviour:
- Reset: synchronous, active-low, sampled at the rising edge of clk.
  - While reset_n = 0, the following are forced to 0: cpu_gnt, scr_gnt, mem_load, cpu_rvalid, scr_rvalid, cpu_rdata, scr_rdata, mem_addr, mem_in.
  - Internal state after reset: state = IDLE, last_winner = SCR (so the CPU wins the first tie), burst_cnt = 0.
  - Reset mid-operation: any pending read return is discarded and no rvalid is issued.
- Grant timing:
  - Grant is combinational from req inputs and registered state.
  - At most one gnt high per cycle; gnt is high only while the matching req is high.
  - A requester that sees gnt may change or drop req/addr/data on the next cycle.
- Memory drive:
  - mem_addr, mem_load and mem_in follow the winner combinationally.
  - mem_load = cpu_gnt & cpu_we. A screen grant never writes.
  - With no grant: mem_load = 0, mem_addr holds its last value, mem_in holds its last value.
- Read return:
  - A granted read at cycle N gives rvalid = 1 on that requester at cycle N+1, with rdata = mem_out. Latency is 1 cycle, one pulse per read.
  - rdata holds its value when rvalid = 0.
  - Writes produce no rvalid.
- States:
  - IDLE: no recent owner. Arbitrate round-robin using last_winner.
  - CPU: last grant went to CPU.
    - Both req → SCR wins (round-robin).
    - Only one req → that requester wins.
  - SCR_BURST: last grant went to screen with scr_lock = 1; burst_cnt counts consecutive screen grants.
    - scr_req & scr_lock & burst_cnt < MAX_BURST → SCR wins, even if cpu_req is high.
    - burst_cnt == MAX_BURST & cpu_req → CPU wins, burst_cnt clears, go to CPU.
    - cpu_req = 0 → screen may continue past MAX_BURST. burst_cnt saturates at MAX_BURST.
  - Transition rules:
    - Any cycle with no req → IDLE. last_winner is kept.
    - SCR grant with scr_lock = 0 → state CPU-equivalent round-robin (last_winner = SCR), burst_cnt = 0.
    - scr_lock dropping mid-burst ends the burst immediately, and the next tie goes to the CPU.
- Boundary conditions:
  - Simultaneous first requests after reset → CPU.
  - Back-to-back CPU-only reads: a grant every cycle, throughput 1 access/cycle.
  - burst_cnt never wraps.

Decomposition:
- Package hack_mem_pkg: ADDR_W, DATA_W constants; owner_t enum {OWN_CPU, OWN_SCR}; state_t enum {IDLE, CPU, SCR_BURST}.
- Sub-module rr_arb2: 2-way round-robin arbiter with inputs req[1:0] and last_winner, output one-hot gnt.
- Burst counter and read-return pipeline register (rd_pending, rd_owner) live in the top.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with cpu_req = scr_req = 1 → all gnt/rvalid/mem_load 0. After release, the first grant is cpu_gnt.
- CPU write then read: write addr 0x0010 data 0xBEEF → mem_load = 1 that cycle. Read 0x0010 the next cycle → cpu_rvalid = 1 one cycle later, cpu_rdata = 0xBEEF. scr_rvalid stays 0.
- Continuous contention, scr_lock = 0, both req held 8 cycles → grants alternate CPU, SCR, CPU, SCR… Each read returns rvalid to the correct owner, one cycle later.
- Burst with MAX_BURST = 8: scr_lock = 1, both req held → 8 consecutive scr_gnt, then 1 cpu_gnt, then the screen resumes.
- Lock release mid-burst: drop scr_lock after 3 screen grants, cpu_req high → the next grant is CPU and burst_cnt is 0.
- Reset mid-read: read granted at cycle N, reset_n = 0 at N+1 → no rvalid at N+1. Outputs are 0 and the round-robin restarts CPU-first.
